// File: rtl/run_ctrl_if.sv
// Handshake, status and data-memory signals shared between run_ctrl and its host/core.
// The slave modport is the controller's view; master is the host/core side.
interface run_ctrl_if #(
    parameter int unsigned CW = 16
) ();
    logic          req;
    logic          core_done;
    logic          core_mem_wr;
    logic [7:0]    core_addr;
    logic [7:0]    core_wdata;
    logic          host_mem_req;
    logic          host_mem_wr;
    logic [7:0]    host_addr;
    logic [7:0]    host_wdata;
    logic          host_gnt;
    logic          mem_wr_en;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    modport slave (
        input  req, core_done, core_mem_wr, core_addr, core_wdata,
        input  host_mem_req, host_mem_wr, host_addr, host_wdata,
        output host_gnt, mem_wr_en, mem_addr, mem_wdata,
        output core_rst, busy, done, timeout, cycles
    );

    modport master (
        output req, core_done, core_mem_wr, core_addr, core_wdata,
        output host_mem_req, host_mem_wr, host_addr, host_wdata,
        input  host_gnt, mem_wr_en, mem_addr, mem_wdata,
        input  core_rst, busy, done, timeout, cycles
    );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset/run/done, counts RUN cycles and arbitrates the data memory.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_ctrl #(
    parameter int unsigned CW      = 16,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned TMAX    = 16'hFFF0
) (
    input  logic      clk,
    input  logic      reset,
    run_ctrl_if.slave bus
);

    localparam int unsigned HW = 4;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cyc_q, cyc_d, cyc_inc;
    logic          to_q, to_d;
    logic          core_rst_q, busy_q, done_q;
    logic          host_win;

    // Next-state, cycle counter and watchdog
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        cyc_inc = (cyc_q == {CW{1'b1}}) ? cyc_q : cyc_q + CW'(1);
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    cyc_d   = '0;
                    to_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_q == HW'(RST_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                // core_done wins over a watchdog hit in the same cycle
                if (bus.core_done) begin
                    state_d = S_DONE;
                end else if (WD_EN && (cyc_inc == TMAX_C)) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cyc_q      <= '0;
            to_q       <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cyc_q      <= cyc_d;
            to_q       <= to_d;
            core_rst_q <= (state_d != S_RUN);
            busy_q     <= (state_d == S_HOLD) || (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Host owns memory only while the core is parked; forced off during reset
    assign host_win = reset && bus.host_mem_req && ((state_q == S_IDLE) || (state_q == S_DONE));

    assign bus.host_gnt  = host_win;
    assign bus.mem_wr_en = host_win ? bus.host_mem_wr
                                    : (reset && bus.core_mem_wr && (state_q == S_RUN));
    assign bus.mem_addr  = host_win ? bus.host_addr  : bus.core_addr;
    assign bus.mem_wdata = host_win ? bus.host_wdata : bus.core_wdata;

    assign bus.core_rst = core_rst_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.timeout  = to_q;
    assign bus.cycles   = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: expectations queued as stimulus is driven, popped at each sample point.
module tb_run_ctrl;
    localparam int unsigned CW = 5;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    run_ctrl_if #(.CW(CW)) bus ();

    run_ctrl #(.CW(CW), .RST_CYC(2), .TMAX(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %0h required <entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 1'b1;
        bus.core_done = 1'b0;
        bus.core_mem_wr = 1'b0;
        bus.core_addr = 8'h00;
        bus.core_wdata = 8'h00;
        bus.host_mem_req = 1'b1;
        bus.host_mem_wr = 1'b1;
        bus.host_addr = 8'h40;
        bus.host_wdata = 8'hA5;
        #1 reset = 1'b0;

        // Held in reset with req high
        sb_push("rst_core_rst", 1); sb_push("rst_busy", 0); sb_push("rst_done", 0);
        sb_push("rst_timeout", 0); sb_push("rst_cycles", 0);
        sb_push("rst_host_gnt", 0); sb_push("rst_mem_wr_en", 0);
        tick(3);
        sb_check(32'(bus.core_rst)); sb_check(32'(bus.busy)); sb_check(32'(bus.done));
        sb_check(32'(bus.timeout)); sb_check(32'(bus.cycles));
        sb_check(32'(bus.host_gnt)); sb_check(32'(bus.mem_wr_en));

        // Release: IDLE samples req, two HOLD cycles, then RUN
        reset = 1'b1;
        bus.host_mem_wr = 1'b0;
        sb_push("hold1_busy", 1); sb_push("hold1_core_rst", 1); sb_push("hold1_host_gnt", 0);
        tick(1);
        sb_check(32'(bus.busy)); sb_check(32'(bus.core_rst)); sb_check(32'(bus.host_gnt));
        bus.req = 1'b0;
        sb_push("hold2_core_rst", 1); sb_push("hold2_busy", 1);
        tick(1);
        sb_check(32'(bus.core_rst)); sb_check(32'(bus.busy));
        sb_push("run_core_rst", 0); sb_push("run_busy", 1); sb_push("run_cycles0", 0);
        tick(1);
        sb_check(32'(bus.core_rst)); sb_check(32'(bus.busy)); sb_check(32'(bus.cycles));

        // Core owns memory in RUN while the host request stalls
        bus.core_mem_wr = 1'b1;
        bus.core_addr = 8'h10;
        bus.core_wdata = 8'h3C;
        sb_push("run_host_gnt", 0); sb_push("run_mem_addr", 32'h10);
        sb_push("run_mem_wdata", 32'h3C); sb_push("run_mem_wr_en", 1);
        #1;
        sb_check(32'(bus.host_gnt)); sb_check(32'(bus.mem_addr));
        sb_check(32'(bus.mem_wdata)); sb_check(32'(bus.mem_wr_en));
        bus.core_mem_wr = 1'b0;

        sb_push("run_cycles9", 9);
        tick(9);
        sb_check(32'(bus.cycles));
        bus.core_done = 1'b1;
        sb_push("done_done", 1); sb_push("done_busy", 0); sb_push("done_core_rst", 1);
        sb_push("done_cycles", 10); sb_push("done_timeout", 0);
        sb_push("done_host_gnt", 1); sb_push("done_mem_addr", 32'h40);
        tick(1);
        bus.core_done = 1'b0;
        sb_check(32'(bus.done)); sb_check(32'(bus.busy)); sb_check(32'(bus.core_rst));
        sb_check(32'(bus.cycles)); sb_check(32'(bus.timeout));
        sb_check(32'(bus.host_gnt)); sb_check(32'(bus.mem_addr));

        sb_push("idle_done", 0); sb_push("idle_core_rst", 1); sb_push("idle_cycles_held", 10);
        tick(1);
        sb_check(32'(bus.done)); sb_check(32'(bus.core_rst)); sb_check(32'(bus.cycles));

        // Host write in IDLE passes through in the same cycle
        bus.host_mem_wr = 1'b1;
        sb_push("hw_host_gnt", 1); sb_push("hw_mem_wr_en", 1);
        sb_push("hw_mem_addr", 32'h40); sb_push("hw_mem_wdata", 32'hA5);
        #1;
        sb_check(32'(bus.host_gnt)); sb_check(32'(bus.mem_wr_en));
        sb_check(32'(bus.mem_addr)); sb_check(32'(bus.mem_wdata));
        bus.host_mem_req = 1'b0;
        bus.host_mem_wr = 1'b0;
        sb_push("hw_off_gnt", 0); sb_push("hw_off_wr_en", 0);
        #1;
        sb_check(32'(bus.host_gnt)); sb_check(32'(bus.mem_wr_en));

        // Long run without core_done
        tick(1);
        bus.req = 1'b1;
        sb_push("long_start_cycles", 0); sb_push("long_start_busy", 1);
        tick(1);
        sb_check(32'(bus.cycles)); sb_check(32'(bus.busy));
        bus.req = 1'b0;
        tick(2);
        tick(20);
`ifdef RUN_CTRL_TIMEOUT_EN
        sb_push("wd_done", 1); sb_push("wd_timeout", 1); sb_push("wd_cycles", 20);
        sb_check(32'(bus.done)); sb_check(32'(bus.timeout)); sb_check(32'(bus.cycles));
        tick(1);
        bus.req = 1'b1;
        sb_push("wd2_timeout_clr", 0);
        tick(1);
        sb_check(32'(bus.timeout));
        bus.req = 1'b0;
        tick(2);
        tick(19);
        bus.core_done = 1'b1;
        sb_push("wd2_done", 1); sb_push("wd2_timeout", 0); sb_push("wd2_cycles", 20);
        tick(1);
        bus.core_done = 1'b0;
        sb_check(32'(bus.done)); sb_check(32'(bus.timeout)); sb_check(32'(bus.cycles));
        tick(1);
`else
        sb_push("nowd_busy", 1); sb_push("nowd_done", 0);
        sb_push("nowd_cycles", 20); sb_push("nowd_timeout", 0);
        sb_check(32'(bus.busy)); sb_check(32'(bus.done));
        sb_check(32'(bus.cycles)); sb_check(32'(bus.timeout));
        sb_push("sat_cycles", 31);
        tick(11);
        sb_check(32'(bus.cycles));
        sb_push("sat_hold_cycles", 31); sb_push("sat_busy", 1);
        tick(5);
        sb_check(32'(bus.cycles)); sb_check(32'(bus.busy));
        bus.core_done = 1'b1;
        sb_push("sat_done", 1); sb_push("sat_done_cycles", 31);
        tick(1);
        bus.core_done = 1'b0;
        sb_check(32'(bus.done)); sb_check(32'(bus.cycles));
        tick(1);
`endif

        // Reset mid-run aborts immediately and waits for a new req
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        tick(2);
        sb_push("mid_cycles5", 5); sb_push("mid_core_rst", 0);
        tick(5);
        sb_check(32'(bus.cycles)); sb_check(32'(bus.core_rst));
        reset = 1'b0;
        sb_push("abort_cycles", 0); sb_push("abort_core_rst", 1);
        sb_push("abort_busy", 0); sb_push("abort_done", 0);
        #1;
        sb_check(32'(bus.cycles)); sb_check(32'(bus.core_rst));
        sb_check(32'(bus.busy)); sb_check(32'(bus.done));
        tick(1);
        reset = 1'b1;
        sb_push("post_busy", 0); sb_push("post_core_rst", 1); sb_push("post_cycles", 0);
        tick(3);
        sb_check(32'(bus.busy)); sb_check(32'(bus.core_rst)); sb_check(32'(bus.cycles));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CW, default 16, meaning cycle-counter width.
REQ-002 SHALL have parameter RST_CYC, default 2, meaning number of cycles core reset is held after start (range 1..15).
REQ-003 SHALL have parameter TMAX, default 16'hFFF0, meaning watchdog limit in RUN cycles (must be < 2^CW).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  host start request, four-phase level handshake.
REQ-007 SHALL have port core_done  input  1  core end-of-program flag.
REQ-008 SHALL have port core_mem_wr  input  1  core data-memory write enable.
REQ-009 SHALL have port core_addr, core_wdata  input  8 each  core memory address and write data.
REQ-010 SHALL have port host_mem_req  input  1  host memory access request; host_mem_wr  input  1  host write enable.
REQ-011 SHALL have port host_addr, host_wdata  input  8 each  host memory address and write data.
REQ-012 SHALL have port host_gnt  output  1  host owns memory this cycle.
REQ-013 SHALL have port mem_wr_en  output  1; mem_addr, mem_wdata  output  8 each  muxed data-memory port.
REQ-014 SHALL have port core_rst  output  1  active-high reset to core/PC.
REQ-015 SHALL have port busy, done, timeout  output  1 each  run status.
REQ-016 SHALL have port cycles  output  CW  RUN-cycle count of current/last run.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD, RUN, DONE, state registered.
REQ-018 IDLE: core_rst=1, busy=0, done=0; req=1 sampled -> HOLD, cycles cleared to 0, timeout cleared.
REQ-019 HOLD: core_rst=1, busy=1; counts RST_CYC cycles then -> RUN.
REQ-020 RUN: core_rst=0, busy=1; cycles increments by 1 every RUN cycle.
REQ-021 RUN: core_done=1 -> DONE; cycles frozen at value including that cycle.
REQ-022 DONE: done=1, busy=0, core_rst=1, cycles and timeout held; req=0 -> IDLE (done falls next cycle).
REQ-023 req dropped during HOLD or RUN SHALL be ignored; run completes normally.
REQ-024 host_gnt SHALL equal host_mem_req in IDLE and DONE, 0 in HOLD and RUN; host requests in HOLD/RUN stall until grant.
REQ-025 mem_* SHALL be combinational: host_gnt=1 -> host_mem_wr/host_addr/host_wdata; else core_mem_wr gated by RUN, core_addr, core_wdata.
REQ-026 mem_wr_en SHALL be 0 in IDLE/HOLD/DONE unless host_gnt and host_mem_wr.
REQ-027 cycles SHALL saturate at all-ones, never wrap.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, core_rst=1, busy=0, done=0, timeout=0, cycles=0, host_gnt=0, mem_wr_en=0.
REQ-029 reset asserted mid-run SHALL abort the run; after release FSM waits in IDLE for req.

Configuration
REQ-030 With RUN_CTRL_TIMEOUT_EN defined: in RUN, cycles reaching TMAX without core_done SHALL -> DONE with timeout=1; core_done and limit in same cycle -> DONE, timeout=0.
REQ-031 Without RUN_CTRL_TIMEOUT_EN: timeout tied 0, no watchdog; RUN exits only on core_done or reset.

Verification
REQ-032 reset low, req=1 held -> core_rst=1, done=0, cycles=0 until reset releases; then HOLD 2 cycles, RUN.
REQ-033 req=1, core_done pulsed in 10th RUN cycle -> done=1, cycles=10, timeout=0; req=0 -> done=0 next cycle, IDLE.
REQ-034 IDLE, host_mem_req=1, host_mem_wr=1, host_addr=8'h40, host_wdata=8'hA5 -> host_gnt=1, mem_wr_en=1, mem_addr=8'h40, mem_wdata=8'hA5 same cycle.
REQ-035 RUN, host_mem_req=1, core_mem_wr=1, core_addr=8'h10 -> host_gnt=0, mem_addr=8'h10; grant appears in DONE.
REQ-036 RUN_CTRL_TIMEOUT_EN, TMAX=20, core_done never -> DONE after 20 RUN cycles, timeout=1, cycles=20; without macro -> still RUN.
REQ-037 reset pulsed low in RUN at cycles=5 -> immediate IDLE, cycles=0, core_rst=1.
